uart_mem_loader: RTL and testbench

UART boot loader that acts as a second initiator on the SRAM port of the FPGA example top, using the same req/gnt/rvalid protocol the core uses toward memory. It receives a framed program image over an 8N1 UART line, writes it word by word into SRAM, and holds the core in reset until a complete frame with a valid checksum has been stored. It sits beside the core and ahead of the SRAM arbiter; the arbiter gives it priority while `core_rst_no` is low.

---
 rtl/uart_mem_loader_if.sv | 35 +++
 rtl/uart_mem_loader.sv | 325 ++++++++++++++++++++++++++++++++
 tb/tb_uart_mem_loader.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_mem_loader_if.sv
// uart_mem_loader_if: req/gnt/rvalid write port between the UART boot loader
// (master) and the SRAM arbiter (slave).
//   req    master->slave  write request, held until gnt is sampled high
//   gnt    slave->master  request retired in the cycle it is high
//   rvalid slave->master  completes the outstanding write
//   we, be, addr, wdata   master->slave  write attributes, stable while req is high
interface uart_mem_loader_if;
    logic        req;
    logic        gnt;
    logic        rvalid;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;

    modport master (
        output req,
        output we,
        output be,
        output addr,
        output wdata,
        input  gnt,
        input  rvalid
    );

    modport slave (
        input  req,
        input  we,
        input  be,
        input  addr,
        input  wdata,
        output gnt,
        output rvalid
    );
endinterface

// File: rtl/uart_mem_loader.sv
// uart_mem_loader: 8N1 UART boot loader. Receives a frame
//   0xA5 | W (16-bit LE) | 4*W payload bytes | 8-bit sum of payload
// writes the payload word by word into SRAM and holds the core in reset until
// a complete frame with a matching checksum has been stored.
// Ports:
//   clk_sys, rst_sys_n  clock, asynchronous active-low reset
//   uart_rx_i           asynchronous serial input, idles high
//   mem                 write initiator port (req/gnt/rvalid)
//   core_rst_no         core reset, released after a good load
//   busy_o              frame in progress
//   done_o, err_o       sticky status, cleared by the next sync byte
// Div = ClkFreq / BaudRate must be at least 16.
module uart_mem_loader #(
    parameter int unsigned ClkFreq  = 25_000_000,
    parameter int unsigned BaudRate = 115200,
    parameter logic [31:0] MemStart = 32'h0000_0000,
    parameter int unsigned MemSize  = 64 * 1024
) (
    input  logic              clk_sys,
    input  logic              rst_sys_n,
    input  logic              uart_rx_i,
    uart_mem_loader_if.master mem,
    output logic              core_rst_no,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int unsigned Div  = ClkFreq / BaudRate;
    localparam int unsigned Half = Div / 2;
    localparam int unsigned CntW = $clog2(Div);
    localparam logic [CntW-1:0] DivM1  = CntW'(Div - 1);
    localparam logic [CntW-1:0] HalfM1 = CntW'(Half - 1);
    localparam logic [31:0]     MemSizeL = 32'(MemSize);

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_st_e;
    typedef enum logic [2:0] {StSync, StLen0, StLen1, StData, StCsum, StWait} st_e;

    // RX front end
    logic            rx_s1_q, rx_s2_q, rx_prev_q;
    rx_st_e          rx_st_q, rx_st_d;
    logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_sh_q, rx_sh_d;
    logic            rx_valid_q, rx_valid_d;
    logic            rx_ferr_q, rx_ferr_d;

    // Frame FSM
    st_e         st_q, st_d;
    logic [15:0] len_q, len_d;
    logic [15:0] wcnt_q, wcnt_d;
    logic [1:0]  bidx_q, bidx_d;
    logic [31:0] wbuf_q, wbuf_d;
    logic [7:0]  sum_q, sum_d;
    logic [7:0]  csum_q, csum_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        core_rst_q, core_rst_d;

    // Write engine: one slot, at most one outstanding transaction
    logic        slot_q, slot_d;
    logic        req_q, req_d;
    logic        out_q, out_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic        wr_done, slot_free;
    logic        push;
    logic [31:0] push_word, push_addr;
    logic [15:0] wcnt_inc;
    logic        chk_go;
    logic [7:0]  chk_byte;

    // The write completes on rvalid, either in the grant cycle or later.
    assign wr_done   = (req_q && mem.gnt && mem.rvalid) || (out_q && mem.rvalid);
    // A slot freeing this cycle can accept a new word or let the checksum resolve.
    assign slot_free = !slot_q || wr_done;

    always_comb begin
        rx_st_d    = rx_st_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_valid_d = 1'b0;
        rx_ferr_d  = 1'b0;
        unique case (rx_st_q)
            RxIdle: begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_st_d  = RxStart;
                    rx_cnt_d = HalfM1;
                end
            end
            RxStart: begin
                if (rx_cnt_q == '0) begin
                    // Still low at mid start bit: genuine start, else a glitch.
                    if (!rx_s2_q) begin
                        rx_st_d  = RxData;
                        rx_cnt_d = DivM1;
                        rx_bit_d = 3'd0;
                    end else begin
                        rx_st_d = RxIdle;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - CntW'(1);
                end
            end
            RxData: begin
                if (rx_cnt_q == '0) begin
                    rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                    rx_cnt_d = DivM1;
                    if (rx_bit_q == 3'd7) begin
                        rx_st_d = RxStop;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - CntW'(1);
                end
            end
            RxStop: begin
                if (rx_cnt_q == '0) begin
                    rx_valid_d = rx_s2_q;
                    rx_ferr_d  = !rx_s2_q;
                    rx_st_d    = RxIdle;
                end else begin
                    rx_cnt_d = rx_cnt_q - CntW'(1);
                end
            end
            default: rx_st_d = RxIdle;
        endcase
    end

    assign push_word = {rx_sh_q, wbuf_q[31:8]};
    assign push_addr = MemStart + {14'd0, wcnt_q, 2'b00};
    assign wcnt_inc  = wcnt_q + 16'd1;

    always_comb begin
        st_d       = st_q;
        len_d      = len_q;
        wcnt_d     = wcnt_q;
        bidx_d     = bidx_q;
        wbuf_d     = wbuf_q;
        sum_d      = sum_q;
        csum_d     = csum_q;
        done_d     = done_q;
        err_d      = err_q;
        core_rst_d = core_rst_q;
        push       = 1'b0;
        chk_go     = 1'b0;
        chk_byte   = rx_sh_q;
        if (rx_ferr_q) begin
            err_d = 1'b1;
            st_d  = StSync;
        end else begin
            unique case (st_q)
                StSync: begin
                    if (rx_valid_q && rx_sh_q == 8'hA5) begin
                        st_d       = StLen0;
                        core_rst_d = 1'b0;
                        done_d     = 1'b0;
                        err_d      = 1'b0;
                        sum_d      = 8'd0;
                    end
                end
                StLen0: begin
                    if (rx_valid_q) begin
                        len_d[7:0] = rx_sh_q;
                        st_d       = StLen1;
                    end
                end
                StLen1: begin
                    if (rx_valid_q) begin
                        len_d[15:8] = rx_sh_q;
                        wcnt_d      = 16'd0;
                        bidx_d      = 2'd0;
                        sum_d       = 8'd0;
                        if ({14'd0, rx_sh_q, len_q[7:0], 2'b00} > MemSizeL) begin
                            err_d = 1'b1;
                            st_d  = StSync;
                        end else if ({rx_sh_q, len_q[7:0]} == 16'd0) begin
                            st_d = StCsum;
                        end else begin
                            st_d = StData;
                        end
                    end
                end
                StData: begin
                    if (rx_valid_q) begin
                        sum_d  = sum_q + rx_sh_q;
                        wbuf_d = push_word;
                        bidx_d = bidx_q + 2'd1;
                        if (bidx_q == 2'd3) begin
                            if (!slot_free) begin
                                // Overflow: the new word is dropped.
                                err_d = 1'b1;
                                st_d  = StSync;
                            end else begin
                                push   = 1'b1;
                                wcnt_d = wcnt_inc;
                                if (wcnt_inc == len_q) begin
                                    st_d = StCsum;
                                end
                            end
                        end
                    end
                end
                StCsum: begin
                    if (rx_valid_q) begin
                        if (slot_free) begin
                            chk_go = 1'b1;
                        end else begin
                            csum_d = rx_sh_q;
                            st_d   = StWait;
                        end
                    end
                end
                StWait: begin
                    if (slot_free) begin
                        chk_go   = 1'b1;
                        chk_byte = csum_q;
                    end
                end
                default: st_d = StSync;
            endcase
        end
        if (chk_go) begin
            st_d = StSync;
            if (chk_byte == sum_q) begin
                done_d     = 1'b1;
                core_rst_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_comb begin
        slot_d  = slot_q;
        req_d   = req_q;
        out_d   = out_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (req_q && mem.gnt) begin
            req_d = 1'b0;
            out_d = !mem.rvalid;
        end
        if (out_q && mem.rvalid) begin
            out_d = 1'b0;
        end
        if (wr_done) begin
            slot_d = 1'b0;
        end
        if (push) begin
            slot_d  = 1'b1;
            req_d   = 1'b1;
            addr_d  = push_addr;
            wdata_d = push_word;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_st_q    <= RxIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= 3'd0;
            rx_sh_q    <= 8'd0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
            st_q       <= StSync;
            len_q      <= 16'd0;
            wcnt_q     <= 16'd0;
            bidx_q     <= 2'd0;
            wbuf_q     <= 32'd0;
            sum_q      <= 8'd0;
            csum_q     <= 8'd0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            core_rst_q <= 1'b0;
            slot_q     <= 1'b0;
            req_q      <= 1'b0;
            out_q      <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
        end else begin
            rx_s1_q    <= uart_rx_i;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_st_q    <= rx_st_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            rx_valid_q <= rx_valid_d;
            rx_ferr_q  <= rx_ferr_d;
            st_q       <= st_d;
            len_q      <= len_d;
            wcnt_q     <= wcnt_d;
            bidx_q     <= bidx_d;
            wbuf_q     <= wbuf_d;
            sum_q      <= sum_d;
            csum_q     <= csum_d;
            done_q     <= done_d;
            err_q      <= err_d;
            core_rst_q <= core_rst_d;
            slot_q     <= slot_d;
            req_q      <= req_d;
            out_q      <= out_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign mem.req     = req_q;
    assign mem.we      = req_q;
    assign mem.be      = {4{req_q}};
    assign mem.addr    = addr_q;
    assign mem.wdata   = wdata_q;
    assign core_rst_no = core_rst_q;
    assign busy_o      = (st_q != StSync);
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_uart_mem_loader.sv
// Scoreboard bench for uart_mem_loader: frames are sent over the UART line,
// expected SRAM writes are queued as they are issued, and a memory responder
// pops and checks each write at its grant.
module tb_uart_mem_loader;

    localparam int unsigned ClkFreq  = 3_200_000;
    localparam int unsigned BaudRate = 100_000;
    localparam int          Div      = 32;

    logic clk_sys = 1'b0;
    logic rst_sys_n = 1'b0;
    logic uart_rx = 1'b1;
    logic core_rst_no, busy_o, done_o, err_o;

    uart_mem_loader_if mem_bus ();

    uart_mem_loader #(
        .ClkFreq  (ClkFreq),
        .BaudRate (BaudRate),
        .MemStart (32'h0000_0000),
        .MemSize  (64 * 1024)
    ) dut (
        .clk_sys     (clk_sys),
        .rst_sys_n   (rst_sys_n),
        .uart_rx_i   (uart_rx),
        .mem         (mem_bus),
        .core_rst_no (core_rst_no),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    always #5 clk_sys = ~clk_sys;

    int total = 0;
    int bad   = 0;

    logic [63:0] exp_q[$];  // {addr, wdata}
    int gnt_delay = 0;
    int rv_delay  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory responder and write monitor; runs on the falling edge so the
    // values it samples and drives are clear of the DUT's active edge.
    initial begin
        int          wait_cnt = 0;
        int          rv_cnt   = 0;
        logic        have_ref = 1'b0;
        logic        stable   = 1'b1;
        logic [31:0] ref_addr = 32'd0;
        logic [31:0] ref_data = 32'd0;
        logic [63:0] e;
        mem_bus.gnt    = 1'b0;
        mem_bus.rvalid = 1'b0;
        forever begin
            @(negedge clk_sys);
            mem_bus.gnt    = 1'b0;
            mem_bus.rvalid = 1'b0;
            if (!rst_sys_n) begin
                wait_cnt = 0;
                rv_cnt   = 0;
                have_ref = 1'b0;
            end else begin
                if (rv_cnt > 0) begin
                    rv_cnt--;
                    if (rv_cnt == 0) mem_bus.rvalid = 1'b1;
                end
                if (mem_bus.req === 1'b1) begin
                    if (!have_ref) begin
                        ref_addr = mem_bus.addr;
                        ref_data = mem_bus.wdata;
                        have_ref = 1'b1;
                        stable   = 1'b1;
                    end else if (mem_bus.addr !== ref_addr || mem_bus.wdata !== ref_data) begin
                        stable = 1'b0;
                    end
                    if (wait_cnt < gnt_delay) begin
                        wait_cnt++;
                    end else begin
                        mem_bus.gnt = 1'b1;
                        wait_cnt    = 0;
                        have_ref    = 1'b0;
                        if (rv_delay == 0) mem_bus.rvalid = 1'b1;
                        else rv_cnt = rv_delay;
                        if (exp_q.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL unexpected_write: got addr %h data %h, none expected",
                                     mem_bus.addr, mem_bus.wdata);
                        end else begin
                            e = exp_q.pop_front();
                            check("wr_addr", mem_bus.addr, e[63:32]);
                            check("wr_data", mem_bus.wdata, e[31:0]);
                            check("wr_be", {28'd0, mem_bus.be}, 32'hF);
                            check("wr_we", {31'd0, mem_bus.we}, 32'd1);
                            check("wr_stable", {31'd0, stable}, 32'd1);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        repeat (Div) @(posedge clk_sys);
        #1;
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (Div) @(posedge clk_sys);
            #1;
        end
        uart_rx = stop;
        repeat (Div) @(posedge clk_sys);
        #1;
        uart_rx = 1'b1;
        repeat (4) @(posedge clk_sys);
        #1;
    endtask

    task automatic send_bytes(input logic [7:0] bytes[$]);
        foreach (bytes[i]) send_byte(bytes[i], 1'b1);
    endtask

    task automatic expect_basic();
        exp_q.push_back({32'h0000_0000, 32'h1234_5678});
        exp_q.push_back({32'h0000_0004, 32'hDEAD_BEEF});
    endtask

    // 8-bit sum of 78 56 34 12 EF BE AD DE is 0x4C.
    task automatic send_basic_body(input logic [7:0] csum);
        logic [7:0] fr[$];
        fr = {8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, csum};
        send_bytes(fr);
    endtask

    task automatic finish_frame(input string tag, input logic e_done, input logic e_err,
                                input logic e_core);
        int n = 0;
        while (busy_o && n < 1000) begin
            @(negedge clk_sys);
            n++;
        end
        if (busy_o) begin
            total++;
            bad++;
            $display("FAIL %s_idle_timeout: busy still 1 after %0d cycles, need 0", tag, n);
        end
        repeat (20) @(negedge clk_sys);
        check({tag, "_done"}, {31'd0, done_o}, {31'd0, e_done});
        check({tag, "_err"}, {31'd0, err_o}, {31'd0, e_err});
        check({tag, "_core_rst_n"}, {31'd0, core_rst_no}, {31'd0, e_core});
        check({tag, "_writes_left"}, exp_q.size(), 32'd0);
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"}, {31'd0, mem_bus.req}, 32'd0);
        check({tag, "_we"}, {31'd0, mem_bus.we}, 32'd0);
        check({tag, "_be"}, {28'd0, mem_bus.be}, 32'd0);
        check({tag, "_addr"}, mem_bus.addr, 32'd0);
        check({tag, "_wdata"}, mem_bus.wdata, 32'd0);
        check({tag, "_core_rst_n"}, {31'd0, core_rst_no}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
        check({tag, "_done"}, {31'd0, done_o}, 32'd0);
        check({tag, "_err"}, {31'd0, err_o}, 32'd0);
    endtask

    initial begin
        logic [7:0] fr[$];
        repeat (3) @(posedge clk_sys);
        #1;
        check_reset_outputs("reset");
        rst_sys_n = 1'b1;
        repeat (5) @(posedge clk_sys);
        #1;

        // Basic load
        expect_basic();
        send_byte(8'hA5, 1'b1);
        check("busy_after_sync", {31'd0, busy_o}, 32'd1);
        send_basic_body(8'h4C);
        finish_frame("basic", 1'b1, 1'b0, 1'b1);

        // Bad checksum: writes still happen, core stays in reset
        expect_basic();
        send_byte(8'hA5, 1'b1);
        send_basic_body(8'h45);
        finish_frame("badsum", 1'b0, 1'b1, 1'b0);

        // Handshake stall: grant after 5 cycles, rvalid 3 cycles after grant
        gnt_delay = 5;
        rv_delay  = 3;
        expect_basic();
        send_byte(8'hA5, 1'b1);
        send_basic_body(8'h4C);
        finish_frame("stall", 1'b1, 1'b0, 1'b1);
        gnt_delay = 0;
        rv_delay  = 0;

        // Oversize: 4*0x4001 exceeds 64 KiB, no writes
        fr = {8'hA5, 8'h01, 8'h40};
        send_bytes(fr);
        finish_frame("oversize", 1'b0, 1'b1, 1'b0);

        // Zero length with checksum 0
        fr = {8'hA5, 8'h00, 8'h00, 8'h00};
        send_bytes(fr);
        finish_frame("zero_len", 1'b1, 1'b0, 1'b1);

        // Short low glitch inside a frame must not produce a byte
        expect_basic();
        send_byte(8'hA5, 1'b1);
        uart_rx = 1'b0;
        repeat (10) @(posedge clk_sys);
        #1;
        uart_rx = 1'b1;
        repeat (3 * Div) @(posedge clk_sys);
        #1;
        send_basic_body(8'h4C);
        finish_frame("glitch", 1'b1, 1'b0, 1'b1);

        // Stop bit 0 in DATA aborts the frame
        fr = {8'hA5, 8'h02, 8'h00, 8'h78};
        send_bytes(fr);
        send_byte(8'h56, 1'b0);
        repeat (2 * Div) @(posedge clk_sys);
        #1;
        finish_frame("framing", 1'b0, 1'b1, 1'b0);

        // Following good frame clears the error
        expect_basic();
        send_byte(8'hA5, 1'b1);
        send_basic_body(8'h4C);
        finish_frame("recover", 1'b1, 1'b0, 1'b1);

        // Reset in DATA with a write still waiting for grant
        gnt_delay = 100000;
        expect_basic();
        fr = {8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF};
        send_bytes(fr);
        check("pre_reset_req", {31'd0, mem_bus.req}, 32'd1);
        rst_sys_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        gnt_delay = 0;
        repeat (3) @(posedge clk_sys);
        #1;
        rst_sys_n = 1'b1;
        repeat (5) @(posedge clk_sys);
        #1;
        expect_basic();
        send_byte(8'hA5, 1'b1);
        send_basic_body(8'h4C);
        finish_frame("post_reset", 1'b1, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
